// File: rtl/irrig_pkg.sv
// Shared types and constants for the irrigation controller.
// State codes are also the St output encoding.
package irrig_pkg;

  localparam int CNT_W = 8;

  localparam logic [3:0] DEF_LOW_TH  = 4'd4;
  localparam logic [3:0] DEF_HIGH_TH = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WATER = 2'b01,
    ST_SOAK  = 2'b10,
    ST_FAULT = 2'b11
  } irrig_state_e;

  typedef logic [CNT_W-1:0] cnt_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/irrig_ctrl_if.sv
// Sample/control bundle between the irrigation controller and its environment.
// The slave modport is the controller side.
interface irrig_ctrl_if;

  logic       ce;
  logic [3:0] m;
  logic       ack;
  logic       pump;
  logic [1:0] st;
  logic       fault;

  modport master (
    output ce, m, ack,
    input  pump, st, fault
  );

  modport slave (
    input  ce, m, ack,
    output pump, st, fault
  );

endinterface

// File: rtl/irrig_persist.sv
// Dry-sample persistence filter: reached pulses on the tick that completes
// PERSIST consecutive dry ticks.
module irrig_persist
  import irrig_pkg::*;
#(
  parameter int PERSIST = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic dry,
  input  logic clear,
  output logic reached
);

  localparam cnt_t PERSIST_C = cnt_t'(PERSIST);

  cnt_t cnt;
  cnt_t cnt_inc;

  assign cnt_inc = sat_inc(cnt);
  assign reached = tick && dry && !clear && (cnt_inc >= PERSIST_C);

  // Restarting after a hit keeps the count at zero while the FSM is away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      if (clear || !dry || reached) begin
        cnt <= '0;
      end else if (cnt < PERSIST_C) begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/irrig_ctrl.sv
// Soil-moisture irrigation controller: IDLE / WATER / SOAK / FAULT.
// Define IRRIG_TIMEOUT_EN to add the watering timeout and the FAULT state.
module irrig_ctrl
  import irrig_pkg::*;
#(
  parameter logic [3:0] LOW_TH     = DEF_LOW_TH,
  parameter logic [3:0] HIGH_TH    = DEF_HIGH_TH,
  parameter int         PERSIST    = 3,
  parameter int         SOAK_TICKS = 8,
  parameter int         MAX_TICKS  = 20
) (
  input  logic         C,
  input  logic         Clr,
  irrig_ctrl_if.slave  bus
);

  localparam cnt_t SOAK_C = cnt_t'(SOAK_TICKS);

  irrig_state_e state;
  irrig_state_e state_next;
  cnt_t         cnt;
  cnt_t         cnt_inc;
  logic         dry;
  logic         wet;
  logic         reached;
  logic         pump_q;
  logic         pump_d;
  logic         fault_q;
  logic         fault_d;

  assign dry     = (bus.m <= LOW_TH);
  assign wet     = (bus.m >= HIGH_TH);
  assign cnt_inc = sat_inc(cnt);

  irrig_persist #(
    .PERSIST (PERSIST)
  ) u_persist (
    .clk     (C),
    .rst     (Clr),
    .tick    (bus.ce),
    .dry     (dry),
    .clear   (state != ST_IDLE),
    .reached (reached)
  );

`ifdef IRRIG_TIMEOUT_EN
  localparam cnt_t MAX_C = cnt_t'(MAX_TICKS);
`else
  logic unused_cfg;
  assign unused_cfg = ^{bus.ack, fault_q};
`endif

  // The shared run/soak counter restarts on every state change.
  always_ff @(posedge C or posedge Clr) begin
    if (Clr) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pump_q  <= 1'b0;
      fault_q <= 1'b0;
    end else if (bus.ce) begin
      state   <= state_next;
      cnt     <= (state_next != state) ? '0 : cnt_inc;
      pump_q  <= pump_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.ce) begin
      case (state)
        ST_IDLE: begin
          if (reached) state_next = ST_WATER;
        end
        ST_WATER: begin
          if (wet) begin
            state_next = ST_SOAK;
          end
`ifdef IRRIG_TIMEOUT_EN
          else if (cnt_inc == MAX_C) begin
            state_next = ST_FAULT;
          end
`endif
        end
        ST_SOAK: begin
          if (cnt_inc == SOAK_C) state_next = ST_IDLE;
        end
        ST_FAULT: begin
`ifdef IRRIG_TIMEOUT_EN
          if (bus.ack) state_next = ST_IDLE;
`else
          state_next = ST_IDLE;
`endif
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    pump_d  = (state_next == ST_WATER);
    fault_d = (state_next == ST_FAULT);
  end

  assign bus.pump = pump_q;
  assign bus.st   = state;
`ifdef IRRIG_TIMEOUT_EN
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_irrig_ctrl.sv
// Directed bench for irrig_ctrl with default parameters; the timeout
// scenarios follow whichever build of IRRIG_TIMEOUT_EN is compiled.
module tb_irrig_ctrl;

  // {st, pump, fault} expected per state
  localparam logic [3:0] S_IDLE  = 4'b0000;
  localparam logic [3:0] S_WATER = 4'b0110;
  localparam logic [3:0] S_SOAK  = 4'b1000;
  localparam logic [3:0] S_FAULT = 4'b1101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [3:0] obs;

  irrig_ctrl_if bus ();

  irrig_ctrl dut (
    .C   (clk),
    .Clr (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] mv, input logic av);
    bus.m   = mv;
    bus.ack = av;
    bus.ce  = 1'b1;
    @(posedge clk);
    #1;
    bus.ce  = 1'b0;
    bus.ack = 1'b0;
    obs = {bus.st, bus.pump, bus.fault};
  endtask

  task automatic do_reset();
    bus.ce = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic enter_water();
    do_reset();
    repeat (3) tick(4'd2, 1'b0);
  endtask

  task automatic test_reset();
    bus.ce = 1'b1; bus.m = 4'd0; bus.ack = 1'b0;
    #2 rst = 1'b1;
    #1 obs = {bus.st, bus.pump, bus.fault};
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL reset_async got %b want %b", obs, S_IDLE);
    else passes++;
    @(posedge clk); #1;
    obs = {bus.st, bus.pump, bus.fault};
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL reset_hold got %b want %b", obs, S_IDLE);
    else passes++;
    bus.ce = 1'b0;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(4'd0, 1'b0);
      checks++;
      if (obs !== ((i == 3) ? S_WATER : S_IDLE))
        $display("[TB] FAIL reset_release_tick%0d got %b want %b", i, obs,
                 (i == 3) ? S_WATER : S_IDLE);
      else passes++;
    end
  endtask

  task automatic test_persist();
    logic [3:0] seq [6] = '{4'd3, 4'd3, 4'd7, 4'd3, 4'd3, 4'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(seq[i], 1'b0);
      checks++;
      if (obs !== ((i == 5) ? S_WATER : S_IDLE))
        $display("[TB] FAIL persist_tick%0d got %b want %b", i + 1, obs,
                 (i == 5) ? S_WATER : S_IDLE);
      else passes++;
    end
  endtask

  task automatic test_normal_cycle();
    enter_water();
    tick(4'd12, 1'b0);
    checks++;
    if (obs !== S_SOAK) $display("[TB] FAIL cycle_wet got %b want %b", obs, S_SOAK);
    else passes++;
    for (int i = 1; i <= 8; i++) begin
      tick(4'd0, 1'b0);
      checks++;
      if (obs !== ((i == 8) ? S_IDLE : S_SOAK))
        $display("[TB] FAIL cycle_soak%0d got %b want %b", i, obs,
                 (i == 8) ? S_IDLE : S_SOAK);
      else passes++;
    end
    // dry ticks in SOAK must not have pre-loaded the persistence count
    for (int i = 1; i <= 3; i++) begin
      tick(4'd4, 1'b0);
      checks++;
      if (obs !== ((i == 3) ? S_WATER : S_IDLE))
        $display("[TB] FAIL cycle_repersist%0d got %b want %b", i, obs,
                 (i == 3) ? S_WATER : S_IDLE);
      else passes++;
    end
  endtask

  task automatic test_ce_gating();
    enter_water();
    tick(4'd15, 1'b0);
    repeat (3) tick(4'd8, 1'b0);
    bus.ce = 1'b0; bus.m = 4'd0; bus.ack = 1'b1;
    repeat (10) @(posedge clk);
    #1 obs = {bus.st, bus.pump, bus.fault};
    bus.ack = 1'b0;
    checks++;
    if (obs !== S_SOAK) $display("[TB] FAIL ce_frozen got %b want %b", obs, S_SOAK);
    else passes++;
    for (int i = 4; i <= 8; i++) begin
      tick(4'd8, 1'b0);
      checks++;
      if (obs !== ((i == 8) ? S_IDLE : S_SOAK))
        $display("[TB] FAIL ce_soak%0d got %b want %b", i, obs,
                 (i == 8) ? S_IDLE : S_SOAK);
      else passes++;
    end
    bus.ce = 1'b0; bus.m = 4'd0;
    repeat (5) @(posedge clk);
    #1 obs = {bus.st, bus.pump, bus.fault};
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL ce_idle_dry got %b want %b", obs, S_IDLE);
    else passes++;
  endtask

  task automatic test_mid_reset();
    enter_water();
    checks++;
    if (obs !== S_WATER) $display("[TB] FAIL midrst_enter got %b want %b", obs, S_WATER);
    else passes++;
    repeat (2) tick(4'd1, 1'b0);
    #3 rst = 1'b1;
    #1 obs = {bus.st, bus.pump, bus.fault};
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL midrst_async got %b want %b", obs, S_IDLE);
    else passes++;
    #1 rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick(4'd1, 1'b0);
      checks++;
      if (obs !== ((i == 3) ? S_WATER : S_IDLE))
        $display("[TB] FAIL midrst_after%0d got %b want %b", i, obs,
                 (i == 3) ? S_WATER : S_IDLE);
      else passes++;
    end
  endtask

`ifdef IRRIG_TIMEOUT_EN
  task automatic test_timeout();
    enter_water();
    repeat (19) tick(4'd3, 1'b0);
    checks++;
    if (obs !== S_WATER) $display("[TB] FAIL tmo_19 got %b want %b", obs, S_WATER);
    else passes++;
    tick(4'd3, 1'b0);
    checks++;
    if (obs !== S_FAULT) $display("[TB] FAIL tmo_20 got %b want %b", obs, S_FAULT);
    else passes++;
    bus.ce = 1'b0; bus.ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 obs = {bus.st, bus.pump, bus.fault};
    bus.ack = 1'b0;
    checks++;
    if (obs !== S_FAULT) $display("[TB] FAIL tmo_ack_noce got %b want %b", obs, S_FAULT);
    else passes++;
    tick(4'd7, 1'b0);
    checks++;
    if (obs !== S_FAULT) $display("[TB] FAIL tmo_noack got %b want %b", obs, S_FAULT);
    else passes++;
    tick(4'd7, 1'b1);
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL tmo_ack got %b want %b", obs, S_IDLE);
    else passes++;
    tick(4'd3, 1'b1);
    checks++;
    if (obs !== S_IDLE) $display("[TB] FAIL tmo_ack_idle got %b want %b", obs, S_IDLE);
    else passes++;
  endtask

  task automatic test_simultaneous();
    enter_water();
    repeat (19) tick(4'd3, 1'b0);
    tick(4'd12, 1'b0);
    checks++;
    if (obs !== S_SOAK) $display("[TB] FAIL simul_wet_wins got %b want %b", obs, S_SOAK);
    else passes++;
  endtask
`else
  task automatic test_no_timeout();
    enter_water();
    for (int i = 1; i <= 40; i++) begin
      tick(4'd3, i[0]);
      if (i == 20 || i == 40) begin
        checks++;
        if (obs !== S_WATER)
          $display("[TB] FAIL notmo_tick%0d got %b want %b", i, obs, S_WATER);
        else passes++;
      end
    end
  endtask
`endif

  initial begin
    bus.ce = 1'b0; bus.m = 4'd0; bus.ack = 1'b0;
    test_reset();
    test_persist();
    test_normal_cycle();
    test_ce_gating();
    test_mid_reset();
`ifdef IRRIG_TIMEOUT_EN
    test_timeout();
    test_simultaneous();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
